// File: rtl/skinny_pkg.sv
// Shared SKINNY-128-384+ tweakey-schedule constants, FSM type and PT helper.
package skinny_pkg;

  localparam int CELL_W = 8;
  localparam int NCELLS = 16;
  localparam int SKINNY384_ROUNDS = 40;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  localparam logic [3:0] PT [NCELLS] = '{
    4'd9, 4'd15, 4'd8, 4'd13,
    4'd10, 4'd14, 4'd12, 4'd11,
    4'd0, 4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7
  };

  function automatic logic [NCELLS*CELL_W-1:0] pt_perm(
    input logic [NCELLS*CELL_W-1:0] s
  );
    logic [NCELLS*CELL_W-1:0] p;
    p = '0;
    for (int i = 0; i < NCELLS; i++) begin
      p[i*CELL_W +: CELL_W] = s[int'(PT[i])*CELL_W +: CELL_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/tk2_lfsr2_row.sv
// LFSR2 applied to the eight low cells of the TK2 lane.
module tk2_lfsr2_row
  import skinny_pkg::*;
(
  input  logic [8*CELL_W-1:0] row_i,
  output logic [8*CELL_W-1:0] row_o
);

  always_comb begin
    row_o = '0;
    for (int i = 0; i < 8; i++) begin
      row_o[i*CELL_W +: CELL_W] = {
        row_i[i*CELL_W + 6 -: 7],
        row_i[i*CELL_W + 7] ^ row_i[i*CELL_W + 5]
      };
    end
  end

endmodule

// File: rtl/tk2_round_sched.sv
// Sequential TK2 tweakey lane for SKINNY-128-384+ (Romulus-N).
// Optional TK2_RESTORE_EN adds a shadow copy and restore_i re-run.
module tk2_round_sched
  import skinny_pkg::*;
#(
  parameter int ROUNDS = SKINNY384_ROUNDS,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
`ifdef TK2_RESTORE_EN
  input  logic              restore_i,
`endif
  input  logic [127:0]      tk_i,
  output logic [63:0]       rk_o,
  output logic              rk_valid_o,
  input  logic              rk_ready_i,
  output logic [CNT_W-1:0]  round_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [127:0]      tk_o
);

  fsm_e             st_q, st_d;
  logic [127:0]     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     perm;
  logic [63:0]      lfsr_lo;
  logic [127:0]     upd;

`ifdef TK2_RESTORE_EN
  logic [127:0]     shadow_q, shadow_d;
`endif

  assign perm = pt_perm(state_q);

  tk2_lfsr2_row u_lfsr (
    .row_i (perm[63:0]),
    .row_o (lfsr_lo)
  );

  assign upd = {perm[127:64], lfsr_lo};

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef TK2_RESTORE_EN
    shadow_d = shadow_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (start_i) begin
          state_d = tk_i;
          cnt_d   = '0;
          st_d    = RUN;
`ifdef TK2_RESTORE_EN
          shadow_d = tk_i;
        end else if (restore_i) begin
          state_d = shadow_q;
          cnt_d   = '0;
          st_d    = RUN;
`endif
        end
      end
      RUN: begin
        if (rk_ready_i) begin
          state_d = upd;
          // Counter parks on the last index; it never wraps.
          if (cnt_q == CNT_W'(ROUNDS - 1)) begin
            st_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
`ifdef TK2_RESTORE_EN
      shadow_q <= '0;
`endif
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef TK2_RESTORE_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign rk_o       = state_q[63:0];
  assign rk_valid_o = (st_q == RUN);
  assign round_o    = cnt_q;
  assign busy_o     = (st_q != IDLE);
  assign done_o     = (st_q == DONE);
  assign tk_o       = state_q;

endmodule

// File: tb/tb_tk2_round_sched.sv
// Directed, table-driven bench for the TK2 round scheduler.
module tb_tk2_round_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         restore_i = 1'b0;
  logic [127:0] tk_i = '0;
  logic [63:0]  rk_o;
  logic         rk_valid_o;
  logic         rk_ready_i = 1'b0;
  logic [5:0]   round_o;
  logic         busy_o;
  logic         done_o;
  logic [127:0] tk_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] rec [40];

  always #5 clk = ~clk;

  tk2_round_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
`ifdef TK2_RESTORE_EN
    .restore_i  (restore_i),
`endif
    .tk_i       (tk_i),
    .rk_o       (rk_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .round_o    (round_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .tk_o       (tk_o)
  );

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model_upd(input logic [127:0] s);
    int pt [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    logic [127:0] r;
    logic [7:0] c;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      c = s[pt[i]*8 +: 8];
      if (i < 8) c = {c[6:0], c[7] ^ c[5]};
      r[i*8 +: 8] = c;
    end
    return r;
  endfunction

  // mode 0: start_i, 1: restore_i (compare against rec), 2: both
  task automatic run(input logic [127:0] tk, input int stall_at,
                     input bit noise, input int mode);
    logic [127:0] m;
    int r, cyc, st;
    m = tk;
    r = 0;
    cyc = 0;
    st = 0;
    rk_ready_i = 1'b1;
    start_i = (mode != 1);
    restore_i = (mode != 0);
    tk_i = (mode == 1) ? {4{$urandom}} : tk;
    @(negedge clk);
    cyc = 1;
    start_i = 1'b0;
    restore_i = 1'b0;
    tk_i = {4{$urandom}};
    while (r < 40 && cyc < 150) begin
      check($sformatf("slice r%0d", r),
            {61'd0, rk_valid_o, round_o, rk_o},
            {61'd0, 1'b1, 6'(r), m[63:0]});
      if (mode == 1) check("restore match", rk_o, rec[r]);
      if (noise) begin
        start_i = 1'b1;
        tk_i = {4{$urandom}};
      end
      if (r == stall_at && st < 3) begin
        rk_ready_i = 1'b0;
        st++;
      end else begin
        rk_ready_i = 1'b1;
        if (mode != 1) rec[r] = m[63:0];
        m = model_upd(m);
        r++;
      end
      @(negedge clk);
      cyc++;
    end
    rk_ready_i = 1'b1;
    start_i = noise;
    check("rounds issued", 128'(r), 128'd40);
    check("done cycle", 128'(cyc), 128'(41 + st));
    check("done state", {125'd0, done_o, busy_o, rk_valid_o}, 128'b110);
    check("final tk_o", tk_o, m);
    @(negedge clk);
    start_i = 1'b0;
    check("back idle", {126'd0, done_o, busy_o}, 128'd0);
    check("idle tk_o", tk_o, m);
  endtask

  typedef struct {
    logic [7:0] c9;
    logic [7:0] r1c0;
  } vec_t;

  vec_t tbl [4];
  bit saw_done;

  initial begin
    tbl[0] = '{8'h01, 8'h02};
    tbl[1] = '{8'h80, 8'h01};
    tbl[2] = '{8'hA0, 8'h40};
    tbl[3] = '{8'hFF, 8'hFE};

    #1;
    check("reset outs", {rk_valid_o, busy_o, done_o, round_o, tk_o},
          {3'b000, 6'd0, 128'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle hold", {busy_o, tk_o}, 129'd0);

    run(128'd0, -1, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      rk_ready_i = 1'b0;
      start_i = 1'b1;
      tk_i = 128'(tbl[k].c9) << 72;
      @(negedge clk);
      start_i = 1'b0;
      check($sformatf("tbl%0d r0", k), {round_o, rk_o}, 70'd0);
      rk_ready_i = 1'b1;
      @(negedge clk);
      check($sformatf("tbl%0d r1", k), {round_o, rk_o},
            {6'd1, 56'd0, tbl[k].r1c0});
      for (int w = 0; w < 60 && !done_o; w++) @(negedge clk);
      check($sformatf("tbl%0d done", k), 128'(done_o), 128'd1);
      @(negedge clk);
    end

    run(128'h0123456789abcdef_fedcba9876543210, 7, 1'b0, 0);
    run(128'h55aa33cc0ff0a5a5_deadbeefcafef00d, -1, 1'b1, 0);

    // reset mid-run at round 5
    rk_ready_i = 1'b1;
    start_i = 1'b1;
    tk_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset round", 128'(round_o), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid reset", {rk_valid_o, busy_o, done_o, tk_o},
          {3'b000, 128'd0});
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("no done after abort", 128'(saw_done), 128'd0);

`ifdef TK2_RESTORE_EN
    run(128'hfeedface_01020304_a0b0c0d0_99887766, -1, 1'b0, 0);
    run(128'hfeedface_01020304_a0b0c0d0_99887766, -1, 1'b0, 1);
    run(128'h0f0e0d0c0b0a09080706050403020100, -1, 1'b0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
